npu_row_controller: RTL and testbench
=====================================

# npu_row_controller

Parametrised successor row controller for the Mini NPU datapath. It receives one pixel row as a byte stream, hands it to an external convolution engine, and scans the engine's results sequentially for the signed maximum and its index. It then returns the full-width maximum as a multi-byte, back-pressured transmit stream. It sits between the byte link (UART/SPI adapter) and the convolution engine.

## Interface
Parameters:
- ROW_LEN, 32, pixels per row; must be ≥ 3.
- PIX_W, 8, bits per pixel; one pixel per rx beat.
- RES_W, 18, signed result width from the engine.
- RES_CNT, ROW_LEN-2, number of engine results; must be ≥ 1.
- OUT_BYTES, 3, bytes sent for the maximum; requires 8*OUT_BYTES ≥ RES_W.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin frame; sampled in IDLE only.
- rx_data  in  PIX_W  pixel beat.
- rx_valid  in  1  rx beat present.
- rx_ready  out  1  high only in RECEIVE.
- eng_start  out  1  one-cycle pulse launching the engine.
- eng_pixels  out  ROW_LEN*PIX_W  flattened row; pixel i at [i*PIX_W +: PIX_W].
- eng_done  in  1  engine results valid; sampled in COMPUTE only.
- eng_results  in  RES_CNT*RES_W  result j at [j*RES_W +: RES_W], signed.
- tx_data  out  8  outgoing byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts; transfer when tx_valid & tx_ready.
- max_idx  out  $clog2(RES_CNT+1)  index of the last maximum.
- busy  out  1  high in any state except IDLE.
- done_signal  out  1  one-cycle pulse, frame complete.

## Operation
- States: IDLE → RECEIVE → COMPUTE → FIND_MAX → SEND → IDLE.
- IDLE: on start, go to RECEIVE with count=0.
- RECEIVE: each rx_valid & rx_ready stores rx_data at pixel[count]. On count==ROW_LEN-1, go to COMPUTE, pulse eng_start the next cycle, and clear count. Gaps in rx_valid are allowed.
- COMPUTE: on eng_done, load max=result[0], idx=0, count=1.
  - If RES_CNT==1, go directly to SEND.
  - Otherwise go to FIND_MAX.
- FIND_MAX: one result per cycle. When result[count] > max (signed, strict), replace max and idx. On a tie the lowest index wins. After count==RES_CNT-1, go to SEND with byte counter 0.
- SEND: tx_data = byte k of max sign-extended to 8*OUT_BYTES bits, little-endian. k advances on each handshake. After the last byte transfers, return to IDLE and pulse done_signal.
- max_idx holds the last result until the next COMPUTE load.
- Ignored inputs:
  - start outside IDLE.
  - rx_valid outside RECEIVE.
  - eng_done outside COMPUTE.
- pixel row registers retain their contents between frames.

## Timing
- Reset: every output is 0, state is IDLE, and all counters and pixel registers are cleared. rst mid-frame aborts at the next edge; no partial transmit resumes.
- The last rx beat accepted at edge T puts eng_start high during cycle T+1 to T+2.
- eng_done sampled at edge E puts tx_valid high from edge E+RES_CNT.
- tx_valid is registered. tx_data stays stable while tx_valid & !tx_ready.
- The final transfer at edge F makes done_signal high for the cycle after F, with busy=0 in that same cycle.
- Minimum frame: ROW_LEN + 1 + engine latency + RES_CNT + OUT_BYTES cycles.

## Configuration
- NPU_ROW_ARGMAX_EN defined: SEND emits OUT_BYTES+1 bytes. The final byte is max_idx zero-extended or truncated to 8 bits. max_idx is driven as described.
- NPU_ROW_ARGMAX_EN undefined: only OUT_BYTES bytes are sent. Index tracking is removed and max_idx is tied to 0.

## Structure
- Package npu_ctrl_pkg holds:
  - the state enum ctrl_state_t;
  - the default parameter constants;
  - a function for the sign-extend/byte-select of the result.
- Sub-module signed_argmax_scan contains the sequential compare registers (max, idx, count), with load, step and last outputs. The FSM, the rx capture and the tx serialiser stay in npu_row_controller.

## Test plan
Defaults apply. The engine is a bench model with 4-cycle latency. NPU_ROW_ARGMAX_EN is defined unless noted.
- All results 0 except result[17]=1000 → tx bytes 0xE8, 0x03, 0x00, 0x11. done_signal pulses once; max_idx=17.
- All results -9 except -5 at indices 4 and 20 → bytes 0xFB, 0xFF, 0xFF, 0x04 (tie keeps lowest index).
- result[29]=0x1FFFF with all others negative; tx_ready low for 5 cycles at each byte → bytes 0xFF, 0xFF, 0x01, 0x1D. tx_data is held stable during stalls and no byte is duplicated.
- 32 rx beats 0x00..0x1F with random rx_valid gaps, plus start and eng_done pulses during RECEIVE → eng_pixels[7:0]=0x00 and [255:248]=0x1F. eng_start pulses exactly once.
- rst asserted during the second SEND byte → the next cycle has all outputs 0 and busy=0. A following full frame completes correctly.
- Macro undefined, result[0]=-1 as the maximum → exactly three bytes 0xFF, 0xFF, 0xFF; max_idx stays 0.

Source files
------------

// File: rtl/npu_ctrl_pkg.sv
// Shared types, default parameters and result byte-select helper for the Mini NPU row controller.
// Consumers of this package honour NPU_ROW_ARGMAX_EN; the package itself is configuration-independent.
package npu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECEIVE  = 3'd1,
    ST_COMPUTE  = 3'd2,
    ST_FIND_MAX = 3'd3,
    ST_SEND     = 3'd4
  } ctrl_state_t;

  localparam int unsigned DEF_ROW_LEN   = 32;
  localparam int unsigned DEF_PIX_W     = 8;
  localparam int unsigned DEF_RES_W     = 18;
  localparam int unsigned DEF_OUT_BYTES = 3;

  // Widest sign-extended result the byte selector handles (8 output bytes).
  localparam int unsigned MAX_EXT_W = 64;

  // Byte k (little-endian) of a res_w-bit signed value sign-extended to MAX_EXT_W bits.
  function automatic logic [7:0] res_byte(input logic [MAX_EXT_W-1:0] val,
                                          input int unsigned          res_w,
                                          input int unsigned          k);
    logic [MAX_EXT_W-1:0] ext;
    for (int unsigned i = 0; i < MAX_EXT_W; i++) begin
      ext[i] = (i < res_w) ? val[i] : val[res_w-1];
    end
    return ext[k*8 +: 8];
  endfunction

endpackage

// File: rtl/signed_argmax_scan.sv
// Sequential signed arg-max over the engine result vector, one result per step.
// With NPU_ROW_ARGMAX_EN the index register is kept; otherwise max_idx is tied to 0.
module signed_argmax_scan
  import npu_ctrl_pkg::*;
#(
  parameter int unsigned RES_W   = DEF_RES_W,
  parameter int unsigned RES_CNT = DEF_ROW_LEN - 2,
  parameter int unsigned IDX_W   = $clog2(RES_CNT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  logic [RES_CNT*RES_W-1:0] results,
  output logic signed [RES_W-1:0]  max_val,
  output logic [IDX_W-1:0]         max_idx,
  output logic                     last
);

  logic [IDX_W-1:0]        cnt;
  logic signed [RES_W-1:0] cur;

  always_comb begin
    cur  = results[32'(cnt)*RES_W +: RES_W];
    last = (cnt == IDX_W'(RES_CNT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val <= '0;
      cnt     <= '0;
    end else if (load) begin
      max_val <= results[RES_W-1:0];
      cnt     <= IDX_W'(1);
    end else if (step) begin
      // Strict compare: an equal later value never displaces the earlier index.
      if (cur > max_val) max_val <= cur;
      cnt <= cnt + IDX_W'(1);
    end
  end

`ifdef NPU_ROW_ARGMAX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx <= '0;
    end else if (load) begin
      max_idx <= '0;
    end else if (step && (cur > max_val)) begin
      max_idx <= cnt;
    end
  end
`else
  assign max_idx = '0;
`endif

endmodule

// File: rtl/npu_row_controller.sv
// Row controller: captures a pixel row, launches the engine, scans for the signed maximum, sends it bytewise.
// NPU_ROW_ARGMAX_EN appends the arg-max index as one extra transmit byte.
module npu_row_controller
  import npu_ctrl_pkg::*;
#(
  parameter int unsigned ROW_LEN   = DEF_ROW_LEN,
  parameter int unsigned PIX_W     = DEF_PIX_W,
  parameter int unsigned RES_W     = DEF_RES_W,
  parameter int unsigned RES_CNT   = ROW_LEN - 2,
  parameter int unsigned OUT_BYTES = DEF_OUT_BYTES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [PIX_W-1:0]                  rx_data,
  input  logic                              rx_valid,
  output logic                              rx_ready,
  output logic                              eng_start,
  output logic [ROW_LEN*PIX_W-1:0]          eng_pixels,
  input  logic                              eng_done,
  input  logic [RES_CNT*RES_W-1:0]          eng_results,
  output logic [7:0]                        tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  output logic [$clog2(RES_CNT+1)-1:0]      max_idx,
  output logic                              busy,
  output logic                              done_signal
);

  localparam int unsigned IDX_W = $clog2(RES_CNT + 1);
  localparam int unsigned RX_W  = $clog2(ROW_LEN);
`ifdef NPU_ROW_ARGMAX_EN
  localparam int unsigned TX_BYTES = OUT_BYTES + 1;
`else
  localparam int unsigned TX_BYTES = OUT_BYTES;
`endif
  localparam int unsigned TXC_W = $clog2(TX_BYTES + 1);

  ctrl_state_t             state;
  logic [RX_W-1:0]         rx_cnt;
  logic [TXC_W-1:0]        tx_cnt;
  logic                    launch_pend;
  logic                    scan_load;
  logic                    scan_step;
  logic                    scan_last;
  logic signed [RES_W-1:0] scan_max;
  logic [IDX_W-1:0]        scan_idx;
  int unsigned             byte_sel;
  logic [7:0]              next_byte;

  assign rx_ready  = (state == ST_RECEIVE);
  assign busy      = (state != ST_IDLE);
  assign scan_load = (state == ST_COMPUTE) && eng_done;
  assign scan_step = (state == ST_FIND_MAX);
  assign max_idx   = scan_idx;

  signed_argmax_scan #(
    .RES_W   (RES_W),
    .RES_CNT (RES_CNT),
    .IDX_W   (IDX_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .load    (scan_load),
    .step    (scan_step),
    .results (eng_results),
    .max_val (scan_max),
    .max_idx (scan_idx),
    .last    (scan_last)
  );

  // tx_data is loaded one byte ahead: byte 0 on SEND entry, byte k+1 on the handshake of byte k.
  always_comb begin
    byte_sel  = tx_valid ? (32'(tx_cnt) + 32'd1) : 32'd0;
    next_byte = res_byte(MAX_EXT_W'(scan_max), RES_W, byte_sel);
`ifdef NPU_ROW_ARGMAX_EN
    if (byte_sel == OUT_BYTES) next_byte = 8'(scan_idx);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rx_cnt      <= '0;
      tx_cnt      <= '0;
      launch_pend <= 1'b0;
      eng_start   <= 1'b0;
      eng_pixels  <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      done_signal <= 1'b0;
    end else begin
      // eng_start trails the last accepted beat by one cycle through launch_pend.
      eng_start   <= launch_pend;
      launch_pend <= 1'b0;
      done_signal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RECEIVE;
            rx_cnt <= '0;
          end
        end
        ST_RECEIVE: begin
          if (rx_valid) begin
            eng_pixels[32'(rx_cnt)*PIX_W +: PIX_W] <= rx_data;
            if (rx_cnt == RX_W'(ROW_LEN - 1)) begin
              state       <= ST_COMPUTE;
              rx_cnt      <= '0;
              launch_pend <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + RX_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          if (eng_done) begin
            state  <= (RES_CNT == 1) ? ST_SEND : ST_FIND_MAX;
            tx_cnt <= '0;
          end
        end
        ST_FIND_MAX: begin
          if (scan_last) begin
            state  <= ST_SEND;
            tx_cnt <= '0;
          end
        end
        ST_SEND: begin
          if (!tx_valid) begin
            tx_data  <= next_byte;
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            if (tx_cnt == TXC_W'(TX_BYTES - 1)) begin
              tx_valid    <= 1'b0;
              state       <= ST_IDLE;
              done_signal <= 1'b1;
            end else begin
              tx_data <= next_byte;
              tx_cnt  <= tx_cnt + TXC_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_row_controller.sv
// Self-checking bench for npu_row_controller: directed vector table, reset abort, randomized frames.
// Expected byte count follows NPU_ROW_ARGMAX_EN as seen by this compilation.
module tb_npu_row_controller;

  localparam int ROW_LEN   = 32;
  localparam int PIX_W     = 8;
  localparam int RES_W     = 18;
  localparam int RES_CNT   = ROW_LEN - 2;
  localparam int OUT_BYTES = 3;
  localparam int IDX_W     = $clog2(RES_CNT + 1);
`ifdef NPU_ROW_ARGMAX_EN
  localparam bit ARGMAX = 1'b1;
`else
  localparam bit ARGMAX = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst, start, rx_valid, eng_done, tx_ready;
  logic [PIX_W-1:0]           rx_data;
  logic                       rx_ready, eng_start, tx_valid, busy, done_signal;
  logic [ROW_LEN*PIX_W-1:0]   eng_pixels;
  logic [RES_CNT*RES_W-1:0]   eng_results;
  logic [7:0]                 tx_data;
  logic [IDX_W-1:0]           max_idx;

  int n_vec = 0, n_bad = 0;
  int cyc_n = 0, done_cnt = 0, est_cnt = 0, stall_err = 0;
  logic [7:0] txq[$];
  logic [7:0] exp_q[$];
  int exp_idx;
  logic signed [RES_W-1:0] res_m[RES_CNT];
  logic [PIX_W-1:0]        pix_m[ROW_LEN];
  bit   stall_prev = 1'b0;
  logic [7:0] stall_data;

  typedef struct {
    int base; int i1; int v1; int i2; int v2; int stall; bit noise;
    logic [7:0] b0; logic [7:0] b1; logic [7:0] b2; int idx;
  } vec_t;
  vec_t tab[5];

  npu_row_controller #(
    .ROW_LEN(ROW_LEN), .PIX_W(PIX_W), .RES_W(RES_W), .RES_CNT(RES_CNT), .OUT_BYTES(OUT_BYTES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .eng_start(eng_start), .eng_pixels(eng_pixels), .eng_done(eng_done),
    .eng_results(eng_results), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .max_idx(max_idx), .busy(busy), .done_signal(done_signal)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (done_signal) done_cnt++;
    if (eng_start) est_cnt++;
    if (stall_prev && (!tx_valid || tx_data != stall_data)) stall_err++;
    stall_prev = !rst && tx_valid && !tx_ready;
    stall_data = tx_data;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain max over the row, first index holding it, little-endian bytes of the value.
  task automatic model();
    longint mx;
    mx = longint'(res_m[0]);
    for (int j = 1; j < RES_CNT; j++) if (longint'(res_m[j]) > mx) mx = longint'(res_m[j]);
    exp_idx = -1;
    for (int j = 0; j < RES_CNT; j++) if (exp_idx < 0 && longint'(res_m[j]) == mx) exp_idx = j;
    exp_q.delete();
    for (int k = 0; k < OUT_BYTES; k++) exp_q.push_back(8'(mx >>> (8*k)));
    if (ARGMAX) exp_q.push_back(8'(exp_idx));
  endtask

  task automatic run_frame(input int stall, input bit gaps, input bit noise, input int abort_after);
    int g, sl, lat, e_cyc, v_cyc;
    bit seen, got;
    for (int j = 0; j < RES_CNT; j++) eng_results[j*RES_W +: RES_W] = res_m[j];
    txq.delete(); done_cnt = 0; est_cnt = 0; stall_err = 0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < ROW_LEN; i++) begin
      if (gaps) begin
        g = $urandom_range(2, 0);
        repeat (g) begin
          rx_valid = 1'b0;
          if (noise) begin start = 1'b1; eng_done = 1'b1; end
          cyc();
          start = 1'b0; eng_done = 1'b0;
        end
      end
      rx_valid = 1'b1; rx_data = pix_m[i]; cyc();
    end
    rx_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (eng_start) begin lat = c; break; end
    end
    check("eng_start_latency", lat, 1);
    repeat (4) cyc();
    eng_done = 1'b1; cyc(); e_cyc = cyc_n; eng_done = 1'b0;
    seen = 1'b0; got = 1'b0; v_cyc = -1; sl = stall;
    for (int k = 0; k < 400 && !got; k++) begin
      if (abort_after >= 0 && txq.size() == abort_after) begin
        rst = 1'b1; tx_ready = 1'b0; cyc();
        check("abort_busy", busy, 0);
        check("abort_tx_valid", tx_valid, 0);
        check("abort_tx_data", tx_data, 0);
        check("abort_done", done_signal, 0);
        check("abort_eng_start", eng_start, 0);
        check("abort_rx_ready", rx_ready, 0);
        check("abort_max_idx", max_idx, 0);
        check("abort_pixels", |eng_pixels, 0);
        rst = 1'b0;
        return;
      end
      if (tx_valid && !seen) begin seen = 1'b1; v_cyc = cyc_n; end
      if (tx_valid) begin
        if (sl > 0) begin tx_ready = 1'b0; sl--; end
        else begin tx_ready = 1'b1; sl = stall; end
      end else begin
        tx_ready = 1'b0;
      end
      cyc();
      if (done_signal) begin got = 1'b1; check("busy_with_done", busy, 0); end
    end
    tx_ready = 1'b0;
    check("done_seen", got, 1);
    check("tx_valid_latency", v_cyc - e_cyc, RES_CNT);
  endtask

  task automatic finish_frame(input string tag);
    int miss;
    repeat (2) cyc();
    check($sformatf("%s_nbytes", tag), txq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), (k < txq.size()) ? longint'(txq[k]) : -1, exp_q[k]);
    check($sformatf("%s_done_pulses", tag), done_cnt, 1);
    check($sformatf("%s_eng_start_pulses", tag), est_cnt, 1);
    check($sformatf("%s_stall_hold", tag), stall_err, 0);
    check($sformatf("%s_max_idx", tag), max_idx, ARGMAX ? exp_idx : 0);
    miss = 0;
    for (int i = 0; i < ROW_LEN; i++) if (eng_pixels[i*PIX_W +: PIX_W] !== pix_m[i]) miss++;
    check($sformatf("%s_pixel_miss", tag), miss, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    eng_done = 1'b0; tx_ready = 1'b0; eng_results = '0;
    repeat (3) cyc();
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_done", done_signal, 0);
    check("rst_max_idx", max_idx, 0);
    check("rst_pixels", |eng_pixels, 0);
    rst = 1'b0; cyc();

    tab[0] = '{0,       17, 1000,   -1, 0,  0, 1'b1, 8'hE8, 8'h03, 8'h00, 17};
    tab[1] = '{-9,      4,  -5,     20, -5, 0, 1'b0, 8'hFB, 8'hFF, 8'hFF, 4};
    tab[2] = '{-3,      29, 131071, -1, 0,  5, 1'b0, 8'hFF, 8'hFF, 8'h01, 29};
    tab[3] = '{-5,      0,  -1,     -1, 0,  1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 0};
    tab[4] = '{-131072, -1, 0,      -1, 0,  0, 1'b1, 8'h00, 8'h00, 8'hFE, 0};

    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < RES_CNT; j++) begin
        res_m[j] = RES_W'(tab[t].base);
        if (j == tab[t].i1) res_m[j] = RES_W'(tab[t].v1);
        if (j == tab[t].i2) res_m[j] = RES_W'(tab[t].v2);
      end
      for (int i = 0; i < ROW_LEN; i++) pix_m[i] = (t == 0) ? PIX_W'(i) : PIX_W'($urandom);
      exp_q.delete();
      exp_q.push_back(tab[t].b0); exp_q.push_back(tab[t].b1); exp_q.push_back(tab[t].b2);
      if (ARGMAX) exp_q.push_back(8'(tab[t].idx));
      exp_idx = tab[t].idx;
      run_frame(tab[t].stall, 1'b1, tab[t].noise, -1);
      finish_frame($sformatf("vec%0d", t));
      if (t == 0) begin
        check("pix_first", eng_pixels[7:0], 8'h00);
        check("pix_last", eng_pixels[255:248], 8'h1F);
      end
    end

    // Reset while the second byte is presented, then a full clean frame.
    for (int j = 0; j < RES_CNT; j++) res_m[j] = (j == 17) ? RES_W'(1000) : '0;
    for (int i = 0; i < ROW_LEN; i++) pix_m[i] = PIX_W'($urandom);
    run_frame(0, 1'b0, 1'b0, 1);
    repeat (2) cyc();
    check("abort_no_done", done_cnt, 0);
    check("abort_one_byte", txq.size(), 1);
    for (int j = 0; j < RES_CNT; j++) res_m[j] = (j == 4 || j == 20) ? RES_W'(-5) : RES_W'(-9);
    for (int i = 0; i < ROW_LEN; i++) pix_m[i] = PIX_W'($urandom);
    model();
    run_frame(1, 1'b1, 1'b0, -1);
    finish_frame("after_rst");

    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < RES_CNT; j++)
        res_m[j] = (r % 2 == 0) ? RES_W'($urandom) : RES_W'($urandom_range(6, 0)) - RES_W'(3);
      for (int i = 0; i < ROW_LEN; i++) pix_m[i] = PIX_W'($urandom);
      model();
      run_frame($urandom_range(2, 0), 1'b1, r[0], -1);
      finish_frame($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
